boot_loader_arb: RTL
====================

// Module: boot_loader_arb
// PURPOSE
//  Arbitrates the CPU data port of the 16KB code/data RAM between the j1 core and a UART boot loader.
//  While loading, it holds the core in reset, assembles 32-bit words from UART bytes and writes them
//  to RAM. In RUN state the CPU port passes through untouched. Sits between j1, buart and ram16k in top.
// PARAMETERS
//  ADDR_W     12            RAM word-address bits; RAM depth = 2**ADDR_W words
//  SYNC_BYTE  8'hA5         frame start marker
//  TIMEOUT    40_000_000    idle clocks allowed between bytes inside a frame before abort
// PORTS
//  clk          in   1   system clock (fclk)
//  resetq       in   1   asynchronous, active-low reset
//  boot_req     in   1   level; rising edge (sampled on clk) enters SYNC
//  rx_valid     in   1   buart byte available
//  rx_data      in   8   buart received byte
//  rx_rd        out  1   one-cycle pulse: byte consumed
//  cpu_addr     in   16  j1 mem_addr (byte address)
//  cpu_wr       in   1   j1 mem_wr
//  cpu_d        in   32  j1 dout
//  ram_addr     out  16  to ram16k a_addr
//  ram_wr       out  1   to ram16k a_wr
//  ram_d        out  32  to ram16k a_d
//  cpu_resetq   out  1   active-low reset to j1; low while loading
//  busy         out  1   high in any state other than RUN
//  err          out  1   sticky; set on timeout/checksum fail, cleared on next frame's SYNC_BYTE
// BEHAVIOUR
//  Reset: state=RUN, rx_rd=0, ram_wr=0, cpu_resetq=0 for the reset cycle then 1 next cycle, busy=0, err=0.
//  RUN: ram_addr/ram_wr/ram_d = cpu_addr/cpu_wr/cpu_d combinationally; rx_rd=0. boot_req 0->1 -> SYNC.
//  Non-RUN: ram_addr/ram_d driven by loader; cpu_wr ignored; cpu_resetq=0; busy=1.
//  Byte accept: when rx_valid=1 and no rx_rd in the previous cycle, assert rx_rd for 1 cycle and use rx_data.
//   At most one byte per 2 cycles.
//  SYNC: discard bytes != SYNC_BYTE (they are still rx_rd-acked); on SYNC_BYTE: clear err, go LEN0. No timeout in SYNC.
//  LEN0/LEN1: 16-bit word count N, little-endian. N==0 -> DONE (CHKSUM_EN: CHK first).
//  DATA: 4 bytes per word, little-endian (first byte -> bits[7:0]); after 4th byte go WRITE.
//  WRITE: exactly one cycle ram_wr=1, ram_addr = {word_idx, 2'b00} zero-extended to 16 bits; word_idx++;
//   if words written==N -> DONE (or CHK) else DATA.
//  word_idx >= 2**ADDR_W: word consumed, ram_wr stays 0 (no wrap-around), count still advances.
//  DONE: one cycle, cpu_resetq=0; next cycle state=RUN, cpu_resetq=1, word_idx=0; the CPU restarts at address 0.
//  Timeout: in LEN0/LEN1/DATA/CHK, counter reset on each accepted byte; reaching TIMEOUT -> err=1, go SYNC.
//  Partial load on timeout: already-written words remain in RAM; the core stays in reset.
//  boot_req edge while not in RUN: ignored. boot_req level has no effect once edge taken.
//  resetq low mid-load: immediate return to RUN state values above; RAM contents undefined for that frame.
// CONFIGURATION
//  BOOT_CHKSUM_EN defined: after the last data byte, state CHK consumes one byte that must equal the
//   mod-256 sum of all LEN and DATA bytes; match -> DONE; mismatch -> err=1, go SYNC (core held in reset).
//  BOOT_CHKSUM_EN undefined: no CHK state, no checksum byte expected, sum register absent.
// TESTING
//  1 boot_req rise, bytes A5 02 00 | 11 22 33 44 | 55 66 77 88 -> RAM word0=44332211, word1=88776655,
//    two single-cycle ram_wr pulses, cpu_resetq rises 2 cycles after the last write.
//  2 RUN: cpu_addr=0x0010, cpu_wr=1, cpu_d=DEADBEEF -> ram_* mirror same cycle; rx bytes ignored, rx_rd=0.
//  3 Bytes 00 FF A5 00 00 -> 00/FF acked and discarded; N=0 -> DONE, no ram_wr, back to RUN.
//  4 A5 01 00 then 2 data bytes then silence TIMEOUT cycles -> err=1, state SYNC, cpu_resetq stays 0;
//    a new frame with A5 clears err.
//  5 rx_valid held high 10 cycles -> rx_rd pulses on alternate cycles only; resetq low mid-DATA -> RUN, busy=0.
//  6 (BOOT_CHKSUM_EN) A5 01 00 01 02 03 04 chk=0x0B -> write, RUN; chk=0x0C -> err=1, SYNC.

Source files
------------

// File: rtl/boot_loader_arb.sv
// UART boot loader / j1 arbiter for the code RAM data port: passes the CPU through in RUN,
// otherwise holds the core in reset and writes framed UART words. Optional BOOT_CHKSUM_EN adds a checksum byte.
module boot_loader_arb #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 40_000_000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        boot_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_d,
    output logic [15:0] ram_addr,
    output logic        ram_wr,
    output logic [31:0] ram_d,
    output logic        cpu_resetq,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_RUN, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE
`ifdef BOOT_CHKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef BOOT_CHKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state_q, state_d;
    logic        boot_p1;
    logic        rx_rd_p1;
    logic        cpu_resetq_q;
    logic        err_q, err_d;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] tmo_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [31:0] word_q;
`ifdef BOOT_CHKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        accepting, timed, vld_p0, tmo_hit, in_range, run;

    always_comb begin
        accepting = 1'b0;
        timed     = 1'b0;
        case (state_q)
            S_SYNC:                 accepting = 1'b1;
            S_LEN0, S_LEN1, S_DATA: begin accepting = 1'b1; timed = 1'b1; end
`ifdef BOOT_CHKSUM_EN
            S_CHK:                  begin accepting = 1'b1; timed = 1'b1; end
`endif
            default: ;
        endcase
    end

    // A byte is taken only if none was taken last cycle, giving buart time to drop rx_valid.
    assign vld_p0   = accepting && rx_valid && !rx_rd_p1;
    assign tmo_hit  = timed && !vld_p0 && (tmo_q == TIMEOUT - 1);
    assign in_range = (word_idx_q >> ADDR_W) == 16'd0;
    assign run      = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_RUN:   if (boot_req && !boot_p1) state_d = S_SYNC;
            S_SYNC:  if (vld_p0 && rx_data == SYNC_BYTE) begin
                         state_d = S_LEN0;
                         err_d   = 1'b0;
                     end
            S_LEN0:  if (vld_p0) state_d = S_LEN1;
            S_LEN1:  if (vld_p0) state_d = ({rx_data, len_lo_q} == 16'd0) ? S_TAIL : S_DATA;
            S_DATA:  if (vld_p0 && byte_cnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = (word_idx_q + 16'd1 == len_q) ? S_TAIL : S_DATA;
`ifdef BOOT_CHKSUM_EN
            S_CHK:   if (vld_p0) begin
                         if (rx_data == sum_q) begin
                             state_d = S_DONE;
                         end else begin
                             state_d = S_SYNC;
                             err_d   = 1'b1;
                         end
                     end
`endif
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        if (tmo_hit) begin
            state_d = S_SYNC;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q      <= S_RUN;
            boot_p1      <= 1'b0;
            rx_rd_p1     <= 1'b0;
            cpu_resetq_q <= 1'b0;
            err_q        <= 1'b0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            tmo_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            boot_p1      <= boot_req;
            rx_rd_p1     <= vld_p0;
            cpu_resetq_q <= (state_d == S_RUN);
            err_q        <= err_d;
            if (state_q == S_WRITE)
                word_idx_q <= word_idx_q + 16'd1;
            else if (state_q != S_DATA)
                word_idx_q <= 16'd0;
            if (state_q != S_DATA)
                byte_cnt_q <= 2'd0;
            else if (vld_p0)
                byte_cnt_q <= byte_cnt_q + 2'd1;
            tmo_q <= (timed && !vld_p0) ? tmo_q + 32'd1 : 32'd0;
        end
    end

    // Frame payload registers: always written before use within a frame, so no reset.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            case (state_q)
                S_LEN0:  len_lo_q <= rx_data;
                S_LEN1:  len_q    <= {rx_data, len_lo_q};
                S_DATA:  word_q   <= {rx_data, word_q[31:8]};
                default: ;
            endcase
        end
`ifdef BOOT_CHKSUM_EN
        if (state_q == S_SYNC)
            sum_q <= 8'd0;
        else if (vld_p0 && (state_q == S_LEN0 || state_q == S_LEN1 || state_q == S_DATA))
            sum_q <= sum_q + rx_data;
`endif
    end

    assign rx_rd      = vld_p0;
    assign ram_addr   = run ? cpu_addr : 16'({word_idx_q[ADDR_W-1:0], 2'b00});
    assign ram_wr     = run ? cpu_wr : (state_q == S_WRITE && in_range);
    assign ram_d      = run ? cpu_d : word_q;
    assign cpu_resetq = cpu_resetq_q;
    assign busy       = !run;
    assign err        = err_q;

endmodule
